// File: rtl/radix4_div_pkg.sv
// Shared definitions for the radix-4 signed divider: widths, saturation limits
// and the controller state encoding.
package radix4_div_pkg;

    localparam int DVD_W = 16;
    localparam int DVS_W = 8;
    localparam int ITER  = 4;
    localparam int R_W   = DVS_W + 2;

    localparam logic [DVS_W-1:0] Q_MAX = 8'h7F;
    localparam logic [DVS_W-1:0] Q_MIN = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/radix4_div_step.sv
// One restoring radix-4 iteration on magnitudes: shift two dividend bits into
// the partial remainder and subtract the largest multiple of |b| that fits.
module radix4_div_step
    import radix4_div_pkg::*;
(
    input  logic [DVS_W-1:0] r_in,
    input  logic [1:0]       dvd_bits,
    input  logic [DVS_W-1:0] b_mag,
    output logic [DVS_W-1:0] r_out,
    output logic [1:0]       q_digit
);

    logic [R_W-1:0] r_sh;
    logic [R_W-1:0] b1;
    logic [R_W-1:0] b2;
    logic [R_W-1:0] b3;

    assign r_sh = {r_in, dvd_bits};
    assign b1   = {2'b00, b_mag};
    assign b2   = {1'b0, b_mag, 1'b0};
    assign b3   = b1 + b2;

    // The remainder entering a step is below |b|, so the result fits back in DVS_W bits.
    always_comb begin
        q_digit = 2'd0;
        r_out   = r_in;
        if (r_sh >= b3) begin
            q_digit = 2'd3;
            r_out   = DVS_W'(r_sh - b3);
        end else if (r_sh >= b2) begin
            q_digit = 2'd2;
            r_out   = DVS_W'(r_sh - b2);
        end else if (r_sh >= b1) begin
            q_digit = 2'd1;
            r_out   = DVS_W'(r_sh - b1);
        end else begin
            q_digit = 2'd0;
            r_out   = DVS_W'(r_sh);
        end
    end

endmodule

// File: rtl/radix4_divider.sv
// Sequential signed 16/8 divider, two quotient bits per cycle, truncating toward zero.
// Optional build macro DIV_SATURATE_EN: saturate the quotient on overflow instead of zeroing it.
module radix4_divider
    import radix4_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] a,
    input  logic [DVS_W-1:0] b,
    output logic [DVS_W-1:0] quot,
    output logic [DVS_W-1:0] rem,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [1:0]       iter_q, iter_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] b_mag_q, b_mag_d;
    logic [DVS_W-1:0] a_lo_q, a_lo_d;
    logic [DVS_W-1:0] r_q, r_d;
    logic [DVS_W-1:0] q_mag_q, q_mag_d;
    logic             pre_ovf_q, pre_ovf_d;
    logic             dbz_flag_q, dbz_flag_d;
    logic [DVS_W-1:0] res_quot_q, res_quot_d;
    logic [DVS_W-1:0] res_rem_q, res_rem_d;
    logic             res_ovf_q, res_ovf_d;
    logic [DVS_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             start_ok;
    logic [DVD_W:0]   a_abs;
    logic [DVS_W-1:0] b_abs;
    logic [DVS_W-1:0] step_r_in;
    logic [DVS_W-1:0] step_r_out;
    logic [1:0]       step_digit;
    logic             q_neg;
    logic [DVS_W-1:0] q_signed;
    logic [DVS_W-1:0] r_signed;
    logic             post_ovf;
    logic [DVS_W-1:0] sat_quot;

    // The done-pulse cycle still counts as busy, so a start there waits one more cycle.
    assign start_ok  = (state_q == IDLE) && start && !done_q;
    assign a_abs     = a[DVD_W-1] ? (17'd0 - {a[DVD_W-1], a}) : {1'b0, a};
    assign b_abs     = b[DVS_W-1] ? (8'd0 - b) : b;
    // The upper dividend byte seeds the remainder; it is below |b| whenever no overflow is flagged.
    assign step_r_in = (iter_q == 2'd0) ? dvd_q[DVD_W-1:DVS_W] : r_q;

    assign q_neg    = a_neg_q ^ b_neg_q;
    assign q_signed = q_neg ? (8'd0 - q_mag_q) : q_mag_q;
    assign r_signed = a_neg_q ? (8'd0 - r_q) : r_q;
    assign post_ovf = q_neg ? (q_mag_q > 8'd128) : (q_mag_q > 8'd127);

`ifdef DIV_SATURATE_EN
    assign sat_quot = q_neg ? Q_MIN : Q_MAX;
`else
    assign sat_quot = '0;
`endif

    radix4_div_step u_step (
        .r_in     (step_r_in),
        .dvd_bits (dvd_q[DVS_W-1:DVS_W-2]),
        .b_mag    (b_mag_q),
        .r_out    (step_r_out),
        .q_digit  (step_digit)
    );

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        dvd_d      = dvd_q;
        b_mag_d    = b_mag_q;
        a_lo_d     = a_lo_q;
        r_d        = r_q;
        q_mag_d    = q_mag_q;
        pre_ovf_d  = pre_ovf_q;
        dbz_flag_d = dbz_flag_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;
        res_ovf_d  = res_ovf_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;
        done_d     = (state_q == DONE);
        busy_d     = start_ok || (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = RUN;
                    a_neg_d    = a[DVD_W-1];
                    b_neg_d    = b[DVS_W-1];
                    dvd_d      = a_abs[DVD_W-1:0];
                    b_mag_d    = b_abs;
                    a_lo_d     = a[DVS_W-1:0];
                    r_d        = '0;
                    iter_d     = '0;
                    q_mag_d    = '0;
                    quot_d     = '0;
                    rem_d      = '0;
                    ovf_d      = 1'b0;
                    dbz_d      = 1'b0;
                    dbz_flag_d = (b == '0);
                    pre_ovf_d  = (a_abs >= {1'b0, b_abs, 8'h00});
                end
            end
            RUN: begin
                r_d     = step_r_out;
                q_mag_d = {q_mag_q[DVS_W-3:0], step_digit};
                dvd_d   = {dvd_q[DVD_W-3:0], 2'b00};
                iter_d  = iter_q + 2'd1;
                if (iter_q == 2'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (dbz_flag_q) begin
                    res_quot_d = '0;
                    res_rem_d  = a_lo_q;
                    res_ovf_d  = 1'b0;
                end else if (pre_ovf_q || post_ovf) begin
                    res_quot_d = sat_quot;
                    res_rem_d  = '0;
                    res_ovf_d  = 1'b1;
                end else begin
                    res_quot_d = q_signed;
                    res_rem_d  = r_signed;
                    res_ovf_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                quot_d  = res_quot_q;
                rem_d   = res_rem_q;
                ovf_d   = res_ovf_q;
                dbz_d   = dbz_flag_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            dvd_q      <= '0;
            b_mag_q    <= '0;
            a_lo_q     <= '0;
            r_q        <= '0;
            q_mag_q    <= '0;
            pre_ovf_q  <= 1'b0;
            dbz_flag_q <= 1'b0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
            res_ovf_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            dvd_q      <= dvd_d;
            b_mag_q    <= b_mag_d;
            a_lo_q     <= a_lo_d;
            r_q        <= r_d;
            q_mag_q    <= q_mag_d;
            pre_ovf_q  <= pre_ovf_d;
            dbz_flag_q <= dbz_flag_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            res_ovf_q  <= res_ovf_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_radix4_divider.sv
// Self-checking bench for radix4_divider: directed corner cases, handshake timing,
// restart/reset behaviour and randomized operands against an integer-division model.
module tb_radix4_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    radix4_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .quot        (quot),
        .rem         (rem),
        .done        (done),
        .busy        (busy),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: native integer division truncates toward zero, remainder follows the dividend.
    function automatic void model(input logic [15:0] ai, input logic [7:0] bi,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic ov, output logic dz);
        int sa;
        int sb;
        int qt;
        int rt;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        q  = 8'h00;
        r  = 8'h00;
        ov = 1'b0;
        dz = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            r  = ai[7:0];
        end else begin
            qt = sa / sb;
            rt = sa % sb;
            if (qt > 127 || qt < -128) begin
                ov = 1'b1;
`ifdef DIV_SATURATE_EN
                q = (qt > 0) ? 8'h7F : 8'h80;
`endif
            end else begin
                q = qt[7:0];
                r = rt[7:0];
            end
        end
    endfunction

    // Waits for idle, launches one division and returns edges from E0 to the done pulse.
    task automatic do_op(input logic [15:0] ai, input logic [7:0] bi, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        a     = ai;
        b     = bi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        $display("op a=%h b=%h quot=%h rem=%h ovf=%b dbz=%b lat=%0d",
                 ai, bi, quot, rem, overflow, div_by_zero, lat);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({quot, rem, done, busy, overflow, div_by_zero} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got quot=%h rem=%h done=%b busy=%b ovf=%b dbz=%b want all zero",
                     quot, rem, done, busy, overflow, div_by_zero);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [13] = '{16'h0064, 16'hFF9C, 16'h0064, 16'h4000, 16'hC000, 16'h3000,
                                 16'h1234, 16'h8000, 16'h8000, 16'h7FFF, 16'hFF80, 16'h007F, 16'h0080};
        logic [7:0]  tb_ [13] = '{8'h07, 8'h07, 8'hF9, 8'h80, 8'h80, 8'h03,
                                  8'h00, 8'h80, 8'hFF, 8'h80, 8'h01, 8'h01, 8'h01};
        logic [7:0] eq, er;
        logic       eo, ez;
        int         lat;
        for (int i = 0; i < 13; i++) begin
            model(ta[i], tb_[i], eq, er, eo, ez);
            do_op(ta[i], tb_[i], lat);
            checks++;
            if (lat !== 6) begin
                errors++;
                $display("FAIL dir_latency: a=%h b=%h got %0d want 6", ta[i], tb_[i], lat);
            end
            checks++;
            if (quot !== eq) begin
                errors++;
                $display("FAIL dir_quot: a=%h b=%h got %h want %h", ta[i], tb_[i], quot, eq);
            end
            checks++;
            if (rem !== er) begin
                errors++;
                $display("FAIL dir_rem: a=%h b=%h got %h want %h", ta[i], tb_[i], rem, er);
            end
            checks++;
            if (overflow !== eo || div_by_zero !== ez) begin
                errors++;
                $display("FAIL dir_flags: a=%h b=%h got ovf=%b dbz=%b want ovf=%b dbz=%b",
                         ta[i], tb_[i], overflow, div_by_zero, eo, ez);
            end
        end
    endtask

    task automatic test_timing();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        a     = 16'h0064;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // k counts edges after E0; busy holds through E6, done only after E6.
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (busy !== (k <= 6) || done !== (k == 6)) begin
                errors++;
                $display("FAIL timing_handshake: after E%0d got busy=%b done=%b want busy=%b done=%b",
                         k, busy, done, k <= 6, k == 6);
            end
            if (k < 6) begin
                checks++;
                if (quot !== 8'h00 || rem !== 8'h00) begin
                    errors++;
                    $display("FAIL timing_cleared: after E%0d got quot=%h rem=%h want 00 00", k, quot, rem);
                end
            end else begin
                checks++;
                if (quot !== 8'h0E || rem !== 8'h02) begin
                    errors++;
                    $display("FAIL timing_hold: after E%0d got quot=%h rem=%h want 0e 02", k, quot, rem);
                end
            end
        end
        $display("op a=0064 b=07 timing sweep through E8");
    endtask

    task automatic test_back_to_back();
        logic [7:0] eq, er;
        logic       eo, ez;
        int         lat;
        do_op(16'h0064, 8'h07, lat);
        // Still inside the done-pulse cycle: this start must wait one cycle.
        a     = 16'hFF9C;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle_start: after E7 got busy=%b want 0", busy);
        end
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: after E8 got busy=%b want 1", busy);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        model(16'hFF9C, 8'h07, eq, er, eo, ez);
        $display("op a=ff9c b=07 quot=%h rem=%h ovf=%b dbz=%b lat=%0d", quot, rem, overflow, div_by_zero, lat);
        checks++;
        if (lat !== 6 || quot !== eq || rem !== er || overflow !== eo) begin
            errors++;
            $display("FAIL b2b_result: got quot=%h rem=%h ovf=%b lat=%0d want quot=%h rem=%h ovf=%b lat=6",
                     quot, rem, overflow, lat, eq, er, eo);
        end
    endtask

    task automatic test_restart_ignored();
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        a     = 16'h0064;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        a     = 16'h1234;
        b     = 8'h03;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        $display("op a=0064 b=07 with restart in RUN quot=%h rem=%h lat=%0d", quot, rem, lat);
        checks++;
        if (lat !== 6 || quot !== 8'h0E || rem !== 8'h02) begin
            errors++;
            $display("FAIL restart_ignored: got quot=%h rem=%h lat=%0d want quot=0e rem=02 lat=6",
                     quot, rem, lat);
        end
    endtask

    task automatic test_midrun_reset();
        int         n;
        int         seen;
        int         lat;
        logic [7:0] eq, er;
        logic       eo, ez;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        a     = 16'h0064;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({quot, rem, done, busy, overflow, div_by_zero} !== 20'h0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got quot=%h rem=%h done=%b busy=%b ovf=%b dbz=%b want all zero",
                     quot, rem, done, busy, overflow, div_by_zero);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_reset_no_done: got %0d active cycles want 0", seen);
        end
        model(16'hFF9C, 8'hF9, eq, er, eo, ez);
        do_op(16'hFF9C, 8'hF9, lat);
        checks++;
        if (lat !== 6 || quot !== eq || rem !== er || overflow !== eo || div_by_zero !== ez) begin
            errors++;
            $display("FAIL after_reset_result: got quot=%h rem=%h ovf=%b dbz=%b lat=%0d want quot=%h rem=%h ovf=%b dbz=%b lat=6",
                     quot, rem, overflow, div_by_zero, lat, eq, er, eo, ez);
        end
    endtask

    task automatic test_random();
        logic [15:0] ai;
        logic [7:0]  bi;
        logic [7:0]  eq, er;
        logic        eo, ez;
        int          lat;
        int          mode;
        for (int i = 0; i < 60; i++) begin
            ai   = 16'($urandom);
            bi   = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            if (mode == 1) ai = {{5{ai[10]}}, ai[10:0]};
            if (mode == 2) begin
                case ($urandom_range(0, 4))
                    0:       bi = 8'h80;
                    1:       bi = 8'h7F;
                    2:       bi = 8'h01;
                    3:       bi = 8'hFF;
                    default: bi = 8'h00;
                endcase
            end
            if (mode == 3) ai = {{8{ai[7]}}, ai[7:0]};
            model(ai, bi, eq, er, eo, ez);
            do_op(ai, bi, lat);
            checks++;
            if (lat !== 6 || quot !== eq || rem !== er || overflow !== eo || div_by_zero !== ez) begin
                errors++;
                $display("FAIL rand_op: a=%h b=%h got quot=%h rem=%h ovf=%b dbz=%b lat=%0d want quot=%h rem=%h ovf=%b dbz=%b lat=6",
                         ai, bi, quot, rem, overflow, div_by_zero, lat, eq, er, eo, ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timing();
        test_back_to_back();
        test_restart_ignored();
        test_midrun_reset();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
